pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage PipelineCPU (IF, ID, EX, MEM, WB). It drives the PC and pipeline-register write enables, the flush and bubble controls, and the EX-stage operand forwarding selects. It also runs a halt/drain state machine, tracks data-memory wait time, and keeps saturating stall and flush counters. Register fields use the 4-bit ARM encoding, and R15 (PC) is never forwarded.

---
 rtl/pipeline_hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage pipeline (IF, ID, EX, MEM, WB).
// Drives the PC and pipeline-register write enables, the IF/ID flush and the
// ID/EX bubble, and the EX operand forwarding selects. It also runs a
// halt/drain state machine, watches data-memory wait time, and keeps
// saturating stall and flush counters.
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   id_rn, id_rm, id_uses_rn/rm        source registers of the ID instruction
//   ex_rn, ex_rm, ex_rd, ex_is_load    EX instruction fields
//   ex_branch_taken                    taken branch resolved in EX
//   mem_rd, wb_rd, mem_wb_en, wb_wb_en destination registers/enables, MEM and WB
//   dmem_busy                          data memory not ready this cycle
//   halt_req                           level request to halt the pipeline
//   pc_we, if_id_we, ex_mem_we, mem_wb_we   write enables (combinational)
//   if_id_flush, id_ex_bubble          NOP insertion (combinational)
//   fwd_a, fwd_b                       00 reg file, 01 WB, 10 MEM
//   halted, mem_timeout                registered status (timeout is sticky)
//   stall_cnt, flush_cnt               saturating performance counters
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN    | normal execution, hazards resolved by stall/flush/forward
// ST_DRAIN  | fetch stopped, IF/ID flushed, waiting for ID..WB to empty
// ST_HALTED | pipeline empty and frozen until halt_req drops

module pipeline_hazard_ctrl #(
    parameter int REG_BITS     = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int WAIT_LIMIT   = 16,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] id_rn,
    input  logic [REG_BITS-1:0] id_rm,
    input  logic                id_uses_rn,
    input  logic                id_uses_rm,
    input  logic [REG_BITS-1:0] ex_rn,
    input  logic [REG_BITS-1:0] ex_rm,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_is_load,
    input  logic                ex_branch_taken,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                mem_wb_en,
    input  logic                wb_wb_en,
    input  logic                dmem_busy,
    input  logic                halt_req,
    output logic                pc_we,
    output logic                if_id_we,
    output logic                ex_mem_we,
    output logic                mem_wb_we,
    output logic                if_id_flush,
    output logic                id_ex_bubble,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                halted,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    localparam logic [DW-1:0]       DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [WW-1:0]       WAIT_LAST  = WW'(WAIT_LIMIT - 1);
    localparam logic [REG_BITS-1:0] PC_REG     = REG_BITS'(15);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic [WW-1:0] wait_cnt;
    logic          load_use;
    logic          active;
    logic          stall_inc;
    logic          flush_inc;

    assign load_use = ex_is_load &&
                      ((id_uses_rn && (id_rn == ex_rd)) ||
                       (id_uses_rm && (id_rm == ex_rd)));

    // HALTED ignores busy, branch and load-use entirely.
    assign active = (state != ST_HALTED);

    // A busy cycle that is also load-use counts once; a branch masks load-use.
    assign stall_inc = active && (dmem_busy || (!ex_branch_taken && load_use));
    assign flush_inc = active && !dmem_busy && ex_branch_taken;

    // R15 reads the PC, never a forwarded result.
    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != PC_REG) begin
            if (mem_wb_en && (mem_rd == src))
                sel = 2'b10;
            else if (wb_wb_en && (wb_rd == src))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        fwd_a        = fwd_sel(ex_rn);
        fwd_b        = fwd_sel(ex_rm);

        if (reset) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
        end else if (state == ST_HALTED) begin
            // NOPs keep circulating through EX/MEM and MEM/WB.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (dmem_busy) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_we    = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = (state == ST_DRAIN);
        end else if ((state == ST_DRAIN) || halt_req) begin
            pc_we        = 1'b0;
            if_id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            wait_cnt    <= '0;
            halted      <= 1'b0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!dmem_busy && !ex_branch_taken && !load_use && halt_req) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (!dmem_busy) begin
                        if (ex_branch_taken) begin
                            // Branch refetches into ID, so the drain restarts.
                            drain_cnt <= DRAIN_LOAD;
                        end else if (!load_use) begin
                            if (drain_cnt == '0) begin
                                state  <= ST_HALTED;
                                halted <= 1'b1;
                            end else begin
                                drain_cnt <= drain_cnt - DW'(1);
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    if (!halt_req) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase

            if (active && dmem_busy) begin
                if (wait_cnt == WAIT_LAST)
                    mem_timeout <= 1'b1;
                else
                    wait_cnt <= wait_cnt + WW'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (stall_inc && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. Each step drives inputs at the
// falling edge, pushes the expected outputs onto a scoreboard, then pops the
// entry to compare the combinational controls before the rising edge and the
// registered status one time unit after it.

module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rn, id_uses_rm, ex_is_load, ex_branch_taken;
    logic       mem_wb_en, wb_wb_en, dmem_busy, halt_req;
    logic       pc_we, if_id_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic       halted, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pc, ifid, exm, mwb, fl, bu;
        logic [1:0] fa, fb;
        logic       h, to;
        int         sc, fc;
    } exp_t;

    exp_t sb[$];

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_uses_rn      (id_uses_rn),
        .id_uses_rm      (id_uses_rm),
        .ex_rn           (ex_rn),
        .ex_rm           (ex_rm),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_wb_en       (mem_wb_en),
        .wb_wb_en        (wb_wb_en),
        .dmem_busy       (dmem_busy),
        .halt_req        (halt_req),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_we       (mem_wb_we),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .halted          (halted),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic pc, ifid, exm, mwb, fl, bu,
                                input logic [1:0] fa, fb,
                                input logic h, to, input int sc, fc);
        exp_t x;
        x.pc = pc; x.ifid = ifid; x.exm = exm; x.mwb = mwb; x.fl = fl; x.bu = bu;
        x.fa = fa; x.fb = fb; x.h = h; x.to = to; x.sc = sc; x.fc = fc;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        id_rn = 4'd0; id_rm = 4'd0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
        ex_rn = 4'd0; ex_rm = 4'd0; ex_rd = 4'd0; ex_is_load = 1'b0;
        ex_branch_taken = 1'b0; mem_rd = 4'd0; wb_rd = 4'd0;
        mem_wb_en = 1'b0; wb_wb_en = 1'b0; dmem_busy = 1'b0; halt_req = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_rd = 4'd1; id_rn = 4'd1; id_uses_rn = 1'b1;
    endtask

    task automatic cyc(input string tag, input exp_t x);
        exp_t c;
        sb.push_back(x);
        #1;
        c = sb.pop_front();
        chk({tag, ".pc_we"},        32'(pc_we),        32'(c.pc));
        chk({tag, ".if_id_we"},     32'(if_id_we),     32'(c.ifid));
        chk({tag, ".ex_mem_we"},    32'(ex_mem_we),    32'(c.exm));
        chk({tag, ".mem_wb_we"},    32'(mem_wb_we),    32'(c.mwb));
        chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(c.fl));
        chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(c.bu));
        chk({tag, ".fwd_a"},        32'(fwd_a),        32'(c.fa));
        chk({tag, ".fwd_b"},        32'(fwd_b),        32'(c.fb));
        @(posedge clk);
        #1;
        chk({tag, ".halted"},       32'(halted),       32'(c.h));
        chk({tag, ".mem_timeout"},  32'(mem_timeout),  32'(c.to));
        chk({tag, ".stall_cnt"},    32'(stall_cnt),    32'(c.sc));
        chk({tag, ".flush_cnt"},    32'(flush_cnt),    32'(c.fc));
        @(negedge clk);
    endtask

    initial begin
        idle();
        // Reset overrides hazards, busy and branch; nothing counts.
        reset = 1'b1;
        ex_rn = 4'd2; mem_rd = 4'd2; mem_wb_en = 1'b1;
        set_load_use();
        dmem_busy = 1'b1; ex_branch_taken = 1'b1;
        cyc("rst0", mk(0,0,0,0,1,1, 2'b00,2'b00, 0,0, 0,0));
        cyc("rst1", mk(0,0,0,0,1,1, 2'b00,2'b00, 0,0, 0,0));
        reset = 1'b0;
        idle();
        cyc("idle", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 0,0));

        // Forwarding
        ex_rn = 4'd2; ex_rm = 4'd3; mem_rd = 4'd2; wb_rd = 4'd2;
        mem_wb_en = 1'b1; wb_wb_en = 1'b1;
        cyc("fwd_mem", mk(1,1,1,1,0,0, 2'b10,2'b00, 0,0, 0,0));
        mem_wb_en = 1'b0;
        cyc("fwd_wb", mk(1,1,1,1,0,0, 2'b01,2'b00, 0,0, 0,0));
        ex_rn = 4'd15; mem_rd = 4'd15; wb_rd = 4'd15; mem_wb_en = 1'b1;
        cyc("fwd_r15", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 0,0));
        ex_rn = 4'd7; ex_rm = 4'd5; mem_rd = 4'd6; wb_rd = 4'd5;
        cyc("fwd_b_wb", mk(1,1,1,1,0,0, 2'b00,2'b01, 0,0, 0,0));
        ex_rn = 4'd6; ex_rm = 4'd6;
        cyc("fwd_both_mem", mk(1,1,1,1,0,0, 2'b10,2'b10, 0,0, 0,0));
        idle();

        // Load-use
        set_load_use(); id_rm = 4'd3;
        cyc("lu_rn", mk(0,0,1,1,0,1, 2'b00,2'b00, 0,0, 1,0));
        idle();
        cyc("lu_after", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 1,0));
        ex_is_load = 1'b1; ex_rd = 4'd1; id_rn = 4'd1; id_uses_rn = 1'b0;
        cyc("lu_nouse", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 1,0));
        idle();
        ex_rd = 4'd4; id_rm = 4'd4; id_uses_rm = 1'b1;
        cyc("lu_notload", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 1,0));
        ex_is_load = 1'b1;
        cyc("lu_rm", mk(0,0,1,1,0,1, 2'b00,2'b00, 0,0, 2,0));
        idle();

        // Branch, and branch winning over load-use
        ex_branch_taken = 1'b1;
        cyc("br", mk(1,1,1,1,1,1, 2'b00,2'b00, 0,0, 2,1));
        set_load_use();
        cyc("br_lu", mk(1,1,1,1,1,1, 2'b00,2'b00, 0,0, 2,2));
        idle();
        cyc("br_after", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 2,2));

        // 16 busy cycles: load-use on the first adds once, branch on the last is deferred
        for (int i = 1; i <= 16; i++) begin
            idle();
            dmem_busy = 1'b1;
            if (i == 1) set_load_use();
            if (i == 16) ex_branch_taken = 1'b1;
            cyc($sformatf("busy%0d", i),
                mk(0,0,0,0,0,0, 2'b00,2'b00, 0, logic'(i == 16), 2 + i, 2));
        end
        dmem_busy = 1'b0;
        cyc("br_deferred", mk(1,1,1,1,1,1, 2'b00,2'b00, 0,1, 18,3));
        idle();
        cyc("to_sticky", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,1, 18,3));

        // Halt from RUN; halt_req stays high through the drain
        halt_req = 1'b1;
        cyc("halt_entry", mk(0,1,1,1,1,0, 2'b00,2'b00, 0,1, 18,3));
        for (int i = 0; i < 4; i++)
            cyc($sformatf("drain%0d", i),
                mk(0,1,1,1,1,0, 2'b00,2'b00, logic'(i == 3), 1, 18,3));
        dmem_busy = 1'b1; ex_branch_taken = 1'b1; set_load_use();
        cyc("halted_frozen", mk(0,0,1,1,0,1, 2'b00,2'b00, 1,1, 18,3));
        idle();
        cyc("halted_exit", mk(0,0,1,1,0,1, 2'b00,2'b00, 0,1, 18,3));
        cyc("run_again", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,1, 18,3));

        // Halt with busy, branch and load-use inside DRAIN
        halt_req = 1'b1;
        cyc("h2_entry", mk(0,1,1,1,1,0, 2'b00,2'b00, 0,1, 18,3));
        cyc("h2_d3", mk(0,1,1,1,1,0, 2'b00,2'b00, 0,1, 18,3));
        dmem_busy = 1'b1;
        cyc("h2_busy0", mk(0,0,0,0,0,0, 2'b00,2'b00, 0,1, 19,3));
        cyc("h2_busy1", mk(0,0,0,0,0,0, 2'b00,2'b00, 0,1, 20,3));
        dmem_busy = 1'b0;
        cyc("h2_d2", mk(0,1,1,1,1,0, 2'b00,2'b00, 0,1, 20,3));
        ex_branch_taken = 1'b1;
        cyc("h2_br", mk(1,1,1,1,1,1, 2'b00,2'b00, 0,1, 20,4));
        ex_branch_taken = 1'b0; set_load_use();
        cyc("h2_lu", mk(0,0,1,1,1,1, 2'b00,2'b00, 0,1, 21,4));
        idle(); halt_req = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc($sformatf("h2_drain%0d", i),
                mk(0,1,1,1,1,0, 2'b00,2'b00, logic'(i == 3), 1, 21,4));
        halt_req = 1'b0;
        cyc("h2_exit", mk(0,0,1,1,0,1, 2'b00,2'b00, 0,1, 21,4));
        cyc("h2_run", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,1, 21,4));

        // Reset during the second drain cycle
        halt_req = 1'b1;
        cyc("r3_entry", mk(0,1,1,1,1,0, 2'b00,2'b00, 0,1, 21,4));
        cyc("r3_d3", mk(0,1,1,1,1,0, 2'b00,2'b00, 0,1, 21,4));
        reset = 1'b1;
        cyc("r3_reset", mk(0,0,0,0,1,1, 2'b00,2'b00, 0,0, 0,0));
        reset = 1'b0; halt_req = 1'b0;
        cyc("r3_run", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 0,0));

        // wait_cnt clears on a non-busy cycle: 15 + 2 busy never time out
        for (int i = 1; i <= 15; i++) begin
            dmem_busy = 1'b1;
            cyc($sformatf("w15_%0d", i), mk(0,0,0,0,0,0, 2'b00,2'b00, 0,0, i,0));
        end
        dmem_busy = 1'b0;
        cyc("w_gap", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 15,0));
        dmem_busy = 1'b1;
        cyc("w2_1", mk(0,0,0,0,0,0, 2'b00,2'b00, 0,0, 16,0));
        cyc("w2_2", mk(0,0,0,0,0,0, 2'b00,2'b00, 0,0, 17,0));
        dmem_busy = 1'b0;
        cyc("w_end", mk(1,1,1,1,0,0, 2'b00,2'b00, 0,0, 17,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
